// File: rtl/main_unit.sv
// main_unit: mode-driven 8-bit value/index block (off, update, count, enumerate).
// Optional feature: define MAIN_UNIT_SAT_EN to make the count regime saturate at 255.
module main_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] x,
  input  logic [1:0] on,
  input  logic       start,
  output logic [7:0] y,
  output logic [2:0] s,
  output logic       b,
  output logic [1:0] regime,
  output logic       active
);
  // Purpose: regime register plus y/s datapath with an enumeration FSM.
  // Latency: all outputs registered; a new regime takes effect one edge after it loads.
  // Backpressure: none; start is a level request, on is ignored while active.

  typedef enum logic [1:0] {
    ENUM_IDLE = 2'd0,
    ENUM_RUN  = 2'd1,
    ENUM_DONE = 2'd2
  } enum_st_e;

  localparam logic [1:0] REG_OFF    = 2'd0;
  localparam logic [1:0] REG_ENUM   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_UPDATE = 2'd3;

  logic [7:0] y_q, y_d;
  logic [2:0] s_q, s_d;
  logic       b_q, b_d;
  logic [1:0] regime_q, regime_d;
  logic       active_q, active_d;
  enum_st_e   st_q, st_d;
  logic [2:0] s_inc;

  assign s_inc = s_q + 3'd1;

  always_comb begin
    y_d      = y_q;
    s_d      = s_q;
    b_d      = 1'b0;
    active_d = 1'b0;
    regime_d = regime_q;
    st_d     = st_q;

    case (regime_q)
      REG_UPDATE: begin
        y_d = x;
        s_d = 3'd0;
      end
      REG_COUNT: begin
        if (start) begin
          active_d = 1'b1;
          s_d      = s_inc;
          b_d      = (y_q == 8'hFF);
`ifdef MAIN_UNIT_SAT_EN
          if (y_q != 8'hFF) y_d = y_q + 8'd1;
`else
          y_d = y_q + 8'd1;
`endif
        end
      end
      REG_ENUM: begin
        case (st_q)
          ENUM_IDLE: begin
            if (start) begin
              st_d     = ENUM_RUN;
              active_d = 1'b1;
              s_d      = 3'd0;
              b_d      = y_q[0];
            end
          end
          ENUM_RUN: begin
            if (s_q != 3'd7) begin
              active_d = 1'b1;
              s_d      = s_inc;
              b_d      = y_q[s_inc];
            end else begin
              st_d = ENUM_DONE;
            end
          end
          ENUM_DONE: begin
            // one run per start assertion: re-arm only after start drops
            if (!start) st_d = ENUM_IDLE;
          end
          default: st_d = ENUM_IDLE;
        endcase
      end
      default: ;
    endcase

    if (!active_q && (on != REG_OFF)) begin
      regime_d = on;
      if (on != REG_ENUM) st_d = ENUM_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q      <= 8'd0;
      s_q      <= 3'd0;
      b_q      <= 1'b0;
      regime_q <= REG_OFF;
      active_q <= 1'b0;
      st_q     <= ENUM_IDLE;
    end else begin
      y_q      <= y_d;
      s_q      <= s_d;
      b_q      <= b_d;
      regime_q <= regime_d;
      active_q <= active_d;
      st_q     <= st_d;
    end
  end

  assign y      = y_q;
  assign s      = s_q;
  assign b      = b_q;
  assign regime = regime_q;
  assign active = active_q;

endmodule

// File: tb/tb_main_unit.sv
// Bench for main_unit: directed test-plan scenarios plus randomized run against a reference model.
module tb_main_unit;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] x;
  logic [1:0] on;
  logic       start;
  logic [7:0] y;
  logic [2:0] s;
  logic       b;
  logic [1:0] regime;
  logic       active;

  int checks = 0;
  int failures = 0;

  // reference model state
  int m_y, m_s, m_b, m_reg, m_act;
  int m_run, m_armed;

  main_unit dut (
    .clk(clk), .rst(rst), .x(x), .on(on), .start(start),
    .y(y), .s(s), .b(b), .regime(regime), .active(active)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    int oact;
    int oreg;
    oact = m_act;
    oreg = m_reg;
    if (rst) begin
      m_y = 0; m_s = 0; m_b = 0; m_reg = 0; m_act = 0;
      m_run = 0; m_armed = 1;
      return;
    end
    case (oreg)
      0: begin m_b = 0; m_act = 0; end
      3: begin m_y = x; m_s = 0; m_b = 0; m_act = 0; end
      2: begin
        if (start) begin
          m_b = (m_y == 255) ? 1 : 0;
`ifdef MAIN_UNIT_SAT_EN
          m_y = (m_y == 255) ? 255 : m_y + 1;
`else
          m_y = (m_y + 1) % 256;
`endif
          m_s = (m_s + 1) % 8;
          m_act = 1;
        end else begin
          m_b = 0; m_act = 0;
        end
      end
      default: begin
        if (m_run != 0) begin
          if (m_s < 7) begin
            m_s = m_s + 1;
            m_b = (m_y >> m_s) & 1;
            m_act = 1;
          end else begin
            m_run = 0; m_armed = 0; m_b = 0; m_act = 0;
          end
        end else if (m_armed != 0 && start) begin
          m_run = 1; m_s = 0; m_b = m_y & 1; m_act = 1;
        end else begin
          m_b = 0; m_act = 0;
          if (!start) m_armed = 1;
        end
      end
    endcase
    if (oact == 0 && on != 2'd0) begin
      m_reg = on;
      if (on != 2'd1) begin m_run = 0; m_armed = 1; end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; on = 2'd0; start = 1'b0; x = 8'd0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({y, s, b, regime, active} !== 15'd0) begin
      failures++;
      $display("FAIL reset_values: got y=%0d s=%0d b=%0d regime=%0d active=%0d want all 0",
               y, s, b, regime, active);
    end
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({y, s, b, regime, active} !== 15'd0) begin
        failures++;
        $display("FAIL off_ignores_start: cyc %0d got y=%0d s=%0d b=%0d regime=%0d active=%0d want 0",
                 i, y, s, b, regime, active);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_count();
    on = 2'd2;
    tick();
    on = 2'd0;
    checks++;
    if (regime !== 2'd2) begin
      failures++; $display("FAIL count_regime: got %0d want 2", regime);
    end
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (active !== 1'b1 || b !== 1'b0) begin
        failures++;
        $display("FAIL count_active: cyc %0d got active=%0d b=%0d want 1 0", i, active, b);
      end
    end
    checks++;
    if (y !== 8'd10 || s !== 3'd2) begin
      failures++; $display("FAIL count_value: got y=%0d s=%0d want 10 2", y, s);
    end
    start = 1'b0;
    tick();
    checks++;
    if (active !== 1'b0 || y !== 8'd10) begin
      failures++; $display("FAIL count_stop: got active=%0d y=%0d want 0 10", active, y);
    end
  endtask

  task automatic test_update();
    x = 8'd57; on = 2'd3;
    tick();
    on = 2'd0;
    checks++;
    if (regime !== 2'd3 || y !== 8'd10) begin
      failures++; $display("FAIL update_regime: got regime=%0d y=%0d want 3 10", regime, y);
    end
    tick();
    checks++;
    if (y !== 8'd57 || s !== 3'd0) begin
      failures++; $display("FAIL update_load: got y=%0d s=%0d want 57 0", y, s);
    end
    x = 8'd58;
    tick();
    checks++;
    if (y !== 8'd58) begin
      failures++; $display("FAIL update_follow: got y=%0d want 58", y);
    end
  endtask

  task automatic test_enumerate();
    logic [7:0] pat;
    int idx;
    int act_cnt;
    pat = 8'b0011_1001;
    x = 8'd57;
    tick();
    on = 2'd1;
    tick();
    on = 2'd0;
    start = 1'b1;
    idx = 0; act_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (active === 1'b1) begin
        act_cnt++;
        checks++;
        if (idx > 7 || s !== idx[2:0] || b !== pat[idx[2:0]]) begin
          failures++;
          $display("FAIL enum_bit: step %0d got s=%0d b=%0d want s=%0d b=%0d",
                   idx, s, b, idx, pat[idx[2:0]]);
        end
        idx++;
      end
    end
    checks++;
    if (act_cnt != 8) begin
      failures++; $display("FAIL enum_active_len: got %0d want 8", act_cnt);
    end
    checks++;
    if (active !== 1'b0 || s !== 3'd7 || y !== 8'd57 || regime !== 2'd1) begin
      failures++;
      $display("FAIL enum_done: got active=%0d s=%0d y=%0d regime=%0d want 0 7 57 1",
               active, s, y, regime);
    end
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    checks++;
    if (active !== 1'b1 || s !== 3'd0 || b !== 1'b1) begin
      failures++; $display("FAIL enum_rerun: got active=%0d s=%0d b=%0d want 1 0 1", active, s, b);
    end
    for (int i = 0; i < 9; i++) tick();
    start = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    int bcnt;
    int exp_y;
    int exp_bcnt;
`ifdef MAIN_UNIT_SAT_EN
    exp_y = 255; exp_bcnt = 3;
`else
    exp_y = 2; exp_bcnt = 1;
`endif
    x = 8'd250; on = 2'd3;
    tick();
    on = 2'd0;
    tick();
    on = 2'd2;
    tick();
    on = 2'd0;
    start = 1'b1;
    bcnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (b === 1'b1) bcnt++;
    end
    checks++;
    if (y !== 8'(exp_y) || bcnt != exp_bcnt) begin
      failures++;
      $display("FAIL count_wrap: got y=%0d bcycles=%0d want y=%0d bcycles=%0d", y, bcnt, exp_y, exp_bcnt);
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    on = 2'd1;
    tick();
    on = 2'd0;
    start = 1'b1;
    tick();
    tick();
    tick();
    on = 2'd2;
    tick();
    checks++;
    if (regime !== 2'd1 || active !== 1'b1) begin
      failures++; $display("FAIL on_ignored_active: got regime=%0d active=%0d want 1 1", regime, active);
    end
    on = 2'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    checks++;
    if ({y, s, b, regime, active} !== 15'd0) begin
      failures++;
      $display("FAIL reset_abort: got y=%0d s=%0d b=%0d regime=%0d active=%0d want all 0",
               y, s, b, regime, active);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      on    = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
      start = ($urandom_range(0, 4) != 0);
      x     = 8'($urandom);
      tick();
      checks++;
      if (y !== 8'(m_y) || s !== 3'(m_s) || b !== 1'(m_b) ||
          regime !== 2'(m_reg) || active !== 1'(m_act)) begin
        failures++;
        $display("FAIL random_cyc%0d: got y=%0d s=%0d b=%0d reg=%0d act=%0d want y=%0d s=%0d b=%0d reg=%0d act=%0d",
                 i, y, s, b, regime, active, m_y, m_s, m_b, m_reg, m_act);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    m_y = 0; m_s = 0; m_b = 0; m_reg = 0; m_act = 0; m_run = 0; m_armed = 1;
    test_reset();
    test_count();
    test_update();
    test_enumerate();
    test_wrap();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
